// File: rtl/nrf_spi_responder_pkg.sv
// Shared constants, state encoding and command decode for the nRF SPI responder.
package nrf_spi_responder_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned NUM_GPR    = 7;

  localparam logic [2:0]        OP_R_REGISTER   = 3'b000;
  localparam logic [2:0]        OP_W_REGISTER   = 3'b001;
  localparam logic [DATA_W-1:0] OP_R_RX_PAYLOAD = 8'h61;
  localparam logic [DATA_W-1:0] OP_NOP          = 8'hFF;

  localparam logic [ADDR_W-1:0] ADDR_STATUS      = 5'h07;
  localparam logic [ADDR_W-1:0] ADDR_FIFO_STATUS = 5'h17;

  localparam int unsigned RX_DR_BIT    = 6;
  localparam int unsigned RX_EMPTY_BIT = 0;
  localparam int unsigned RX_FULL_BIT  = 1;

  localparam logic [DATA_W-1:0] STATUS_RST = 8'h0E;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_RD_REG,
    ST_WR_REG,
    ST_RD_PLD,
    ST_IGNORE
  } state_e;

  // Maps a received command byte to the state serving its data bytes.
  function automatic state_e decode_cmd(input logic [DATA_W-1:0] cmd);
    state_e st;
    st = ST_IGNORE;
    if (cmd == OP_NOP)                   st = ST_IGNORE;
    else if (cmd == OP_R_RX_PAYLOAD)     st = ST_RD_PLD;
    else if (cmd[7:5] == OP_R_REGISTER)  st = ST_RD_REG;
    else if (cmd[7:5] == OP_W_REGISTER)  st = ST_WR_REG;
    return st;
  endfunction

endpackage

// File: rtl/nrf_spi_responder_byte_fifo.sv
// 4 x 8 first-word-fall-through FIFO; push while full is dropped unless a pop frees a slot.
module byte_fifo
  import nrf_spi_responder_pkg::*;
(
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Push,
  input  logic [DATA_W-1:0] i_Data,
  input  logic              i_Pop,
  output logic [DATA_W-1:0] o_Data,
  output logic              o_Full,
  output logic              o_Empty
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, empty_q;
  logic              push_c, pop_c;

  assign pop_c  = i_Pop && !empty_q;
  assign push_c = i_Push && (!full_q || pop_c);

  always_comb begin
    count_d = count_q;
    if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
    else if (pop_c && !push_c) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(FIFO_DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage carries no reset; validity is tracked by the count.
  always_ff @(posedge i_Clk) begin
    if (push_c) mem_q[wr_ptr_q] <= i_Data;
  end

  assign o_Data  = mem_q[rd_ptr_q];
  assign o_Full  = full_q;
  assign o_Empty = empty_q;

endmodule

// File: rtl/nrf_spi_responder.sv
// SPI mode-0 slave modelling the nRF command interface: STATUS on every command
// byte, register read/write, and an RX payload FIFO fed from a local port.
module nrf_spi_responder
  import nrf_spi_responder_pkg::*;
(
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_SPI_Sck,
  input  logic              i_SPI_Csn,
  input  logic              i_SPI_Mosi,
  output logic              o_SPI_Miso,
  input  logic [DATA_W-1:0] i_Payload_Byte,
  input  logic              i_Payload_Wr,
  output logic              o_IRQ_n,
  output logic              o_Wr_DV,
  output logic [ADDR_W-1:0] o_Wr_Addr,
  output logic [DATA_W-1:0] o_Wr_Data
);

  logic [1:0] sck_sync_q, csn_sync_q, mosi_sync_q;
  logic       sck_prev_q, csn_prev_q;
  logic       sck_s, csn_s, mosi_s;
  logic       sck_rise_c, sck_fall_c, csn_fall_c;

  state_e            state_q;
  logic [2:0]        bit_cnt_q;
  logic [DATA_W-2:0] rx_q;
  logic [DATA_W-1:0] tx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] regs_q [NUM_GPR];
  logic              rx_dr_q;
  logic              irq_n_q;
  logic              wr_dv_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic [DATA_W-1:0] rx_byte_c, status_c, rd_data_c, next_tx_c, fifo_data;
  logic [ADDR_W-1:0] rd_addr_c;
  state_e            next_state_c;
  logic              byte_done_c, commit_c, w1c_c, pop_c;
  logic              fifo_full, fifo_empty;

  // Synchronizers track the pins even during reset so a held CSN never looks like a fresh fall.
  always_ff @(posedge i_Clk) begin
    sck_sync_q  <= {sck_sync_q[0], i_SPI_Sck};
    csn_sync_q  <= {csn_sync_q[0], i_SPI_Csn};
    mosi_sync_q <= {mosi_sync_q[0], i_SPI_Mosi};
    sck_prev_q  <= sck_sync_q[1];
    csn_prev_q  <= csn_sync_q[1];
  end

  assign sck_s      = sck_sync_q[1];
  assign csn_s      = csn_sync_q[1];
  assign mosi_s     = mosi_sync_q[1];
  assign sck_rise_c = sck_s && !sck_prev_q;
  assign sck_fall_c = !sck_s && sck_prev_q;
  assign csn_fall_c = !csn_s && csn_prev_q;

  assign rx_byte_c   = {rx_q, mosi_s};
  assign byte_done_c = sck_rise_c && !csn_s && (bit_cnt_q == 3'd7) && (state_q != ST_IDLE);
  assign commit_c    = byte_done_c && (state_q == ST_WR_REG);
  assign w1c_c       = commit_c && (addr_q == ADDR_STATUS) && rx_byte_c[RX_DR_BIT];

  always_comb begin
    status_c            = STATUS_RST;
    status_c[RX_DR_BIT] = rx_dr_q;
  end

  // Register read port; during CMD the address is still arriving in the shift register.
  always_comb begin
    rd_addr_c = (state_q == ST_CMD) ? rx_byte_c[ADDR_W-1:0] : addr_q;
    rd_data_c = '0;
    if (rd_addr_c < ADDR_W'(NUM_GPR)) begin
      rd_data_c = regs_q[rd_addr_c[2:0]];
    end else if (rd_addr_c == ADDR_STATUS) begin
      rd_data_c = status_c;
    end else if (rd_addr_c == ADDR_FIFO_STATUS) begin
      rd_data_c[RX_FULL_BIT]  = fifo_full;
      rd_data_c[RX_EMPTY_BIT] = fifo_empty;
    end
  end

  always_comb begin
    next_state_c = (state_q == ST_CMD) ? decode_cmd(rx_byte_c) : state_q;
    next_tx_c    = '0;
    case (next_state_c)
      ST_RD_REG: next_tx_c = rd_data_c;
      ST_RD_PLD: next_tx_c = fifo_empty ? '0 : fifo_data;
      default:   next_tx_c = '0;
    endcase
  end

  assign pop_c = byte_done_c && (next_state_c == ST_RD_PLD) && !fifo_empty;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      rx_dr_q   <= 1'b0;
      irq_n_q   <= 1'b1;
      wr_dv_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < int'(NUM_GPR); i++) regs_q[i] <= '0;
    end else begin
      wr_dv_q <= 1'b0;
      irq_n_q <= !rx_dr_q;
      // A push in the same cycle as a W1C clear leaves RX_DR set.
      if (i_Payload_Wr)  rx_dr_q <= 1'b1;
      else if (w1c_c)    rx_dr_q <= 1'b0;

      if (commit_c) begin
        wr_dv_q   <= 1'b1;
        wr_addr_q <= addr_q;
        wr_data_q <= rx_byte_c;
        if (addr_q < ADDR_W'(NUM_GPR)) regs_q[addr_q[2:0]] <= rx_byte_c;
      end

      if (csn_s) begin
        state_q   <= ST_IDLE;
        tx_q      <= '0;
        bit_cnt_q <= '0;
      end else if (state_q == ST_IDLE) begin
        if (csn_fall_c) begin
          state_q   <= ST_CMD;
          tx_q      <= status_c;
          bit_cnt_q <= '0;
        end
      end else begin
        if (sck_rise_c) begin
          rx_q      <= rx_byte_c[DATA_W-2:0];
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
        // The fall after the 8th rise must keep the freshly loaded MSB on MISO.
        if (sck_fall_c && (bit_cnt_q != 3'd0)) tx_q <= {tx_q[DATA_W-2:0], 1'b0};
        if (byte_done_c) begin
          tx_q <= next_tx_c;
          if (state_q == ST_CMD) begin
            state_q <= next_state_c;
            addr_q  <= rx_byte_c[ADDR_W-1:0];
          end else if (state_q == ST_WR_REG) begin
            state_q <= ST_IGNORE;
          end
        end
      end
    end
  end

  byte_fifo u_fifo (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Push  (i_Payload_Wr),
    .i_Data  (i_Payload_Byte),
    .i_Pop   (pop_c),
    .o_Data  (fifo_data),
    .o_Full  (fifo_full),
    .o_Empty (fifo_empty)
  );

  assign o_SPI_Miso = tx_q[DATA_W-1];
  assign o_IRQ_n    = irq_n_q;
  assign o_Wr_DV    = wr_dv_q;
  assign o_Wr_Addr  = wr_addr_q;
  assign o_Wr_Data  = wr_data_q;

endmodule

// File: tb/tb_nrf_spi_responder.sv
// Bench for nrf_spi_responder: SPI master tasks, a transaction-level model of the
// radio's registers and payload queue, a directed table, corner sequences and random traffic.
module tb_nrf_spi_responder;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       i_SPI_Sck = 1'b0;
  logic       i_SPI_Csn = 1'b1;
  logic       i_SPI_Mosi = 1'b0;
  logic       o_SPI_Miso;
  logic [7:0] i_Payload_Byte = 8'h00;
  logic       i_Payload_Wr = 1'b0;
  logic       o_IRQ_n;
  logic       o_Wr_DV;
  logic [4:0] o_Wr_Addr;
  logic [7:0] o_Wr_Data;

  nrf_spi_responder dut (
    .i_Clk          (i_Clk),
    .i_Rst          (i_Rst),
    .i_SPI_Sck      (i_SPI_Sck),
    .i_SPI_Csn      (i_SPI_Csn),
    .i_SPI_Mosi     (i_SPI_Mosi),
    .o_SPI_Miso     (o_SPI_Miso),
    .i_Payload_Byte (i_Payload_Byte),
    .i_Payload_Wr   (i_Payload_Wr),
    .o_IRQ_n        (o_IRQ_n),
    .o_Wr_DV        (o_Wr_DV),
    .o_Wr_Addr      (o_Wr_Addr),
    .o_Wr_Data      (o_Wr_Data)
  );

  always #5 i_Clk = ~i_Clk;

  int n_vec = 0;
  int n_err = 0;

  int         wr_cnt = 0;
  logic [4:0] wr_a_seen = '0;
  logic [7:0] wr_d_seen = '0;

  always @(negedge i_Clk) begin
    if (o_Wr_DV === 1'b1) begin
      wr_cnt    = wr_cnt + 1;
      wr_a_seen = o_Wr_Addr;
      wr_d_seen = o_Wr_Data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: radio state at transaction granularity.
  logic [7:0] m_regs [7];
  bit         m_rx_dr;
  logic [7:0] m_q [$];

  function automatic void m_reset();
    for (int i = 0; i < 7; i++) m_regs[i] = 8'h00;
    m_rx_dr = 1'b0;
    m_q.delete();
  endfunction

  function automatic logic [7:0] m_status();
    return m_rx_dr ? 8'h4E : 8'h0E;
  endfunction

  function automatic logic [7:0] m_read(input logic [4:0] a);
    if (a < 5'd7)   return m_regs[a];
    if (a == 5'h07) return m_status();
    if (a == 5'h17) return {6'b0, m_q.size() >= 4, m_q.size() == 0};
    return 8'h00;
  endfunction

  function automatic logic [7:0] m_pop();
    if (m_q.size() == 0) return 8'h00;
    return m_q.pop_front();
  endfunction

  function automatic void m_push(input logic [7:0] b);
    m_rx_dr = 1'b1;
    if (m_q.size() < 4) m_q.push_back(b);
  endfunction

  function automatic void m_write(input logic [4:0] a, input logic [7:0] d);
    if (a < 5'd7) m_regs[a] = d;
    else if (a == 5'h07 && d[6]) m_rx_dr = 1'b0;
  endfunction

  // SPI master primitives; SCK half period is 4 system clocks.
  task automatic csn_start();
    i_SPI_Csn = 1'b0;
    repeat (6) @(negedge i_Clk);
  endtask

  task automatic csn_end();
    repeat (4) @(negedge i_Clk);
    i_SPI_Csn = 1'b1;
    repeat (6) @(negedge i_Clk);
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits, input bit push_last,
                      output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      i_SPI_Mosi = mo[i];
      repeat (4) @(negedge i_Clk);
      mi[i] = o_SPI_Miso;
      i_SPI_Sck = 1'b1;
      if (push_last && i == 0) begin
        // Strobe the push into the exact cycle the write commits.
        repeat (2) @(negedge i_Clk);
        i_Payload_Wr = 1'b1;
        @(negedge i_Clk);
        i_Payload_Wr = 1'b0;
        check("commit_align_wr_dv", 32'(o_Wr_DV), 32'd1);
        @(negedge i_Clk);
      end else begin
        repeat (4) @(negedge i_Clk);
      end
      i_SPI_Sck = 1'b0;
    end
  endtask

  task automatic push(input logic [7:0] b);
    i_Payload_Byte = b;
    i_Payload_Wr   = 1'b1;
    @(negedge i_Clk);
    i_Payload_Wr   = 1'b0;
    m_push(b);
  endtask

  logic [7:0] got [5];

  // One CSN window: command plus nd data bytes, checked against the model.
  task automatic run_txn(input logic [7:0] cmd, input logic [7:0] d0, input int nd);
    logic [7:0] exp [5];
    int         wr_before;
    bit         exp_wr;
    wr_before = wr_cnt;
    exp_wr    = (cmd[7:5] == 3'b001) && (nd >= 1);
    exp[0]    = m_status();
    for (int k = 1; k <= nd; k++) begin
      if (cmd[7:5] == 3'b000)  exp[k] = m_read(cmd[4:0]);
      else if (cmd == 8'h61)   exp[k] = m_pop();
      else                     exp[k] = 8'h00;
    end
    if (cmd == 8'h61) void'(m_pop());
    csn_start();
    for (int k = 0; k <= nd; k++) xfer((k == 0) ? cmd : d0, 8, 1'b0, got[k]);
    csn_end();
    for (int k = 0; k <= nd; k++)
      check($sformatf("model_cmd%02h_byte%0d", cmd, k), 32'(got[k]), 32'(exp[k]));
    if (exp_wr) m_write(cmd[4:0], d0);
    check($sformatf("model_cmd%02h_wr_cnt", cmd), 32'(wr_cnt - wr_before), 32'(exp_wr));
    if (exp_wr) begin
      check($sformatf("model_cmd%02h_wr_addr", cmd), 32'(wr_a_seen), 32'(cmd[4:0]));
      check($sformatf("model_cmd%02h_wr_data", cmd), 32'(wr_d_seen), 32'(d0));
    end
    check($sformatf("model_cmd%02h_irq_n", cmd), 32'(o_IRQ_n), 32'(!m_rx_dr));
  endtask

  typedef struct {
    int         npush;
    logic [7:0] pbase;
    logic [7:0] cmd;
    logic [7:0] d0;
    int         nd;
    logic [7:0] exp_st;
    logic [7:0] exp_d [4];
    bit         exp_wr;
    logic [4:0] wr_a;
    logic [7:0] wr_d;
    bit         exp_irq_n;
  } vec_t;

  function automatic vec_t mk(input int npush, input logic [7:0] pbase, input logic [7:0] cmd,
                              input logic [7:0] d0, input int nd, input logic [7:0] st,
                              input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                              input logic [7:0] e3, input bit ew, input logic [4:0] wa,
                              input logic [7:0] wd, input bit irq_n);
    vec_t v;
    v.npush = npush; v.pbase = pbase; v.cmd = cmd; v.d0 = d0; v.nd = nd; v.exp_st = st;
    v.exp_d[0] = e0; v.exp_d[1] = e1; v.exp_d[2] = e2; v.exp_d[3] = e3;
    v.exp_wr = ew; v.wr_a = wa; v.wr_d = wd; v.exp_irq_n = irq_n;
    return v;
  endfunction

  vec_t vt [11];

  initial begin
    logic [7:0] mi;
    int         wb;

    // Pushes step by the base value: 0x11,0x22,0x33 or 0x01..0x05.
    vt[0]  = mk(0, 8'h00, 8'hFF, 8'h00, 0, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00, 0, 5'h00, 8'h00, 1);
    vt[1]  = mk(0, 8'h00, 8'h23, 8'hA5, 1, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00, 1, 5'h03, 8'hA5, 1);
    vt[2]  = mk(0, 8'h00, 8'h03, 8'hFF, 1, 8'h0E, 8'hA5, 8'h00, 8'h00, 8'h00, 0, 5'h00, 8'h00, 1);
    vt[3]  = mk(3, 8'h11, 8'h17, 8'hFF, 1, 8'h4E, 8'h00, 8'h00, 8'h00, 8'h00, 0, 5'h00, 8'h00, 0);
    vt[4]  = mk(0, 8'h00, 8'h61, 8'hFF, 4, 8'h4E, 8'h11, 8'h22, 8'h33, 8'h00, 0, 5'h00, 8'h00, 0);
    vt[5]  = mk(0, 8'h00, 8'h17, 8'hFF, 1, 8'h4E, 8'h01, 8'h00, 8'h00, 8'h00, 0, 5'h00, 8'h00, 0);
    vt[6]  = mk(5, 8'h01, 8'h17, 8'hFF, 1, 8'h4E, 8'h02, 8'h00, 8'h00, 8'h00, 0, 5'h00, 8'h00, 0);
    vt[7]  = mk(0, 8'h00, 8'h61, 8'hFF, 4, 8'h4E, 8'h01, 8'h02, 8'h03, 8'h04, 0, 5'h00, 8'h00, 0);
    vt[8]  = mk(0, 8'h00, 8'h17, 8'hFF, 1, 8'h4E, 8'h01, 8'h00, 8'h00, 8'h00, 0, 5'h00, 8'h00, 0);
    vt[9]  = mk(0, 8'h00, 8'h27, 8'h40, 1, 8'h4E, 8'h00, 8'h00, 8'h00, 8'h00, 1, 5'h07, 8'h40, 1);
    vt[10] = mk(0, 8'h00, 8'hFF, 8'h00, 0, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00, 0, 5'h00, 8'h00, 1);

    m_reset();
    repeat (5) @(negedge i_Clk);
    i_Rst = 1'b0;
    @(negedge i_Clk);
    check("reset_miso", 32'(o_SPI_Miso), 32'd0);
    check("reset_irq_n", 32'(o_IRQ_n), 32'd1);
    check("reset_wr_dv", 32'(o_Wr_DV), 32'd0);
    check("reset_wr_addr", 32'(o_Wr_Addr), 32'd0);
    check("reset_wr_data", 32'(o_Wr_Data), 32'd0);

    // Directed table.
    for (int r = 0; r < 11; r++) begin
      for (int p = 0; p < vt[r].npush; p++) push(8'((p + 1) * vt[r].pbase));
      wb = wr_cnt;
      run_txn(vt[r].cmd, vt[r].d0, vt[r].nd);
      check($sformatf("row%0d_status", r), 32'(got[0]), 32'(vt[r].exp_st));
      for (int k = 1; k <= vt[r].nd; k++)
        check($sformatf("row%0d_data%0d", r, k), 32'(got[k]), 32'(vt[r].exp_d[k-1]));
      check($sformatf("row%0d_wr_pulses", r), 32'(wr_cnt - wb), 32'(vt[r].exp_wr));
      if (vt[r].exp_wr) begin
        check($sformatf("row%0d_wr_addr", r), 32'(wr_a_seen), 32'(vt[r].wr_a));
        check($sformatf("row%0d_wr_data", r), 32'(wr_d_seen), 32'(vt[r].wr_d));
      end
      check($sformatf("row%0d_irq_n", r), 32'(o_IRQ_n), 32'(vt[r].exp_irq_n));
    end

    // RX_DR clear and payload push land in the same cycle: set wins.
    wb = wr_cnt;
    i_Payload_Byte = 8'h77;
    csn_start();
    xfer(8'h27, 8, 1'b0, mi);
    check("w1c_race_status", 32'(mi), 32'h0E);
    xfer(8'h40, 8, 1'b1, mi);
    csn_end();
    m_push(8'h77);
    check("w1c_race_wr_pulses", 32'(wr_cnt - wb), 32'd1);
    check("w1c_race_irq_n", 32'(o_IRQ_n), 32'd0);
    run_txn(8'hFF, 8'h00, 0);
    check("w1c_race_rx_dr_kept", 32'(got[0]), 32'h4E);
    run_txn(8'h27, 8'h40, 1);
    run_txn(8'h61, 8'h00, 1);
    check("w1c_race_payload", 32'(got[1]), 32'h77);

    // CSN rises after 4 bits of a write data byte.
    run_txn(8'h24, 8'h3C, 1);
    wb = wr_cnt;
    csn_start();
    xfer(8'h24, 8, 1'b0, mi);
    xfer(8'h5A, 4, 1'b0, mi);
    csn_end();
    check("abort_wr_pulses", 32'(wr_cnt - wb), 32'd0);
    check("abort_miso_idle", 32'(o_SPI_Miso), 32'd0);
    run_txn(8'h04, 8'h00, 1);
    check("abort_reg_kept", 32'(got[1]), 32'h3C);

    // Reset in the middle of a command; the rest of that window is ignored.
    push(8'h99);
    repeat (3) @(negedge i_Clk);
    check("pre_reset_irq_n", 32'(o_IRQ_n), 32'd0);
    wb = wr_cnt;
    csn_start();
    xfer(8'h21, 4, 1'b0, mi);
    i_Rst = 1'b1;
    repeat (2) @(negedge i_Clk);
    i_Rst = 1'b0;
    @(negedge i_Clk);
    m_reset();
    check("midrst_miso", 32'(o_SPI_Miso), 32'd0);
    check("midrst_irq_n", 32'(o_IRQ_n), 32'd1);
    check("midrst_wr_dv", 32'(o_Wr_DV), 32'd0);
    check("midrst_wr_addr", 32'(o_Wr_Addr), 32'd0);
    check("midrst_wr_data", 32'(o_Wr_Data), 32'd0);
    xfer(8'h21, 4, 1'b0, mi);
    xfer(8'hAA, 8, 1'b0, mi);
    check("midrst_ignored_miso", 32'(mi), 32'd0);
    csn_end();
    check("midrst_no_write", 32'(wr_cnt - wb), 32'd0);
    run_txn(8'hFF, 8'h00, 0);
    run_txn(8'h01, 8'h00, 1);
    run_txn(8'h17, 8'h00, 1);

    // Random traffic against the model.
    for (int it = 0; it < 40; it++) begin
      int         kind;
      logic [7:0] cmd;
      int         nd;
      for (int p = $urandom_range(0, 3); p > 0; p--) push(8'($urandom));
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          case ($urandom_range(0, 2))
            0:       cmd = {3'b000, 5'($urandom_range(0, 7))};
            1:       cmd = 8'h17;
            default: cmd = {3'b000, 5'($urandom)};
          endcase
          nd = $urandom_range(1, 3);
        end
        1: begin
          cmd = {3'b001, 5'($urandom_range(0, 7))};
          nd  = $urandom_range(1, 2);
        end
        2: begin
          cmd = 8'h61;
          nd  = $urandom_range(1, 4);
        end
        default: begin
          cmd = {1'b1, 7'($urandom)};
          nd  = $urandom_range(0, 2);
        end
      endcase
      run_txn(cmd, 8'($urandom), nd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
